capctl_seq: RTL and testbench

- AXI4-Lite write-only master that plays a programmed sequence of register writes into the capctl slave (odata at 0x0, oenable at 0x4).
- Each entry is {sel, data, delay}. The block issues one AXI-Lite write per entry, waits for B, then idles `delay` cycles before the next entry.
- Sits beside the CPU-side AXI-Lite fabric in front of capctl. Gives deterministic, cycle-timed pin waveforms without software in the loop.

---
 rtl/capctl_pkg.sv | 17 +
 rtl/capctl_seq_mem.sv | 17 +
 rtl/capctl_seq.sv | 120 ++++++++++++
 tb/tb_capctl_seq.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/capctl_pkg.sv
// capctl_pkg: shared capctl register map, AXI response codes, pattern entry layout and sequencer states
package capctl_pkg;
  localparam logic [31:0] CAPCTL_ODATA_OFF   = 32'h0;
  localparam logic [31:0] CAPCTL_OENABLE_OFF = 32'h4;
  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] EXOKAY = 2'b01;
  localparam logic [1:0] SLVERR = 2'b10;
  localparam logic [1:0] DECERR = 2'b11;
  localparam int CAPCTL_DW   = 6;
  localparam int CAPCTL_DLYW = 8;
  typedef struct packed {
    logic                   sel;
    logic [CAPCTL_DW-1:0]   data;
    logic [CAPCTL_DLYW-1:0] delay;
  } capctl_seq_entry_t;
  typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, RESP = 2'd2, WAIT = 2'd3} capctl_seq_state_t;
endpackage

// File: rtl/capctl_seq_mem.sv
// capctl_seq_mem: DEPTH-entry pattern table, one sync write port and one async read port, no reset
module capctl_seq_mem #(
  parameter int DEPTH = 16,
  parameter int EW    = 15
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [EW-1:0]            wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [EW-1:0]            rdata
);
  logic [EW-1:0] mem [DEPTH];
  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;
  assign rdata = mem[raddr];
endmodule

// File: rtl/capctl_seq.sv
// capctl_seq: AXI4-Lite write-only master replaying a pattern table into capctl (odata 0x0, oenable 0x4)
// Ports: clk, reset_n (sync, active low); start/len/busy/done/err control; pat_we/pat_waddr/pat_wdata
// table load; m_aw*/m_w*/m_b* AXI4-Lite write channels. Defining CAPCTL_SEQ_LOOP_EN adds input loop,
// which makes the sequence wrap to entry 0 instead of ending.
module capctl_seq
  import capctl_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int DW    = 6,
  parameter int DLYW  = 8,
  parameter int AW    = 32,
  parameter int STRBW = 1
) (
  input  logic                       clk,
  input  logic                       reset_n,
`ifdef CAPCTL_SEQ_LOOP_EN
  input  logic                       loop,
`endif
  input  logic                       start,
  input  logic [$clog2(DEPTH+1)-1:0] len,
  output logic                       busy,
  output logic                       done,
  output logic                       err,
  input  logic                       pat_we,
  input  logic [$clog2(DEPTH)-1:0]   pat_waddr,
  input  logic [DW+DLYW:0]           pat_wdata,
  output logic                       m_awvalid,
  input  logic                       m_awready,
  output logic [AW-1:0]              m_awaddr,
  output logic                       m_wvalid,
  input  logic                       m_wready,
  output logic [31:0]                m_wdata,
  output logic [STRBW-1:0]           m_wstrb,
  input  logic                       m_bvalid,
  output logic                       m_bready,
  input  logic [1:0]                 m_bresp
);
  localparam int IW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH+1);
  typedef struct packed {
    logic            sel;
    logic [DW-1:0]   data;
    logic [DLYW-1:0] delay;
  } entry_t;
  capctl_seq_state_t state;
  logic [IW-1:0] idx, last_idx, rd_addr;
  logic [LW-1:0] len_c;
  logic [DLYW-1:0] cnt, cur_delay;
  logic [DW+DLYW:0] mem_rd;
  entry_t ent;
  logic wr_en, last, adv, fin, load, loop_en;
`ifdef CAPCTL_SEQ_LOOP_EN
  assign loop_en = loop;
`else
  assign loop_en = 1'b0;
`endif
  assign wr_en = pat_we && state == IDLE;
  assign last = idx == last_idx;
  // Read ahead: the port already addresses the entry to be issued on the next load.
  assign rd_addr = (state == IDLE || last) ? '0 : idx + 1'b1;
  // Forward a same-cycle table write so a start alongside it sees the new entry.
  assign ent = (wr_en && pat_waddr == rd_addr) ? pat_wdata : mem_rd;
  assign len_c = len > LW'(DEPTH) ? LW'(DEPTH) : len;
  assign adv = (state == RESP && m_bvalid && m_bresp == OKAY && cur_delay == '0) ||
               (state == WAIT && cnt == DLYW'(1));
  assign fin = last && !loop_en;
  assign load = (state == IDLE && start && len != '0) || (adv && !fin);
  assign busy = state != IDLE;
  assign m_bready = state == RESP;
  assign m_wstrb = '1;
  capctl_seq_mem #(.DEPTH(DEPTH), .EW(1+DW+DLYW)) u_mem (
    .clk(clk), .we(wr_en), .waddr(pat_waddr), .wdata(pat_wdata), .raddr(rd_addr), .rdata(mem_rd)
  );
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= IDLE;
      idx <= '0;
      m_awvalid <= 1'b0;
      m_wvalid <= 1'b0;
      done <= 1'b0;
      err <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          err <= 1'b0;
          done <= len == '0;
          last_idx <= IW'(len_c - 1'b1);
        end
        ISSUE: begin
          if (m_awready) m_awvalid <= 1'b0;
          if (m_wready) m_wvalid <= 1'b0;
          if ((!m_awvalid || m_awready) && (!m_wvalid || m_wready)) state <= RESP;
        end
        RESP: if (m_bvalid) begin
          cnt <= cur_delay;
          state <= m_bresp == OKAY ? WAIT : IDLE;
          if (m_bresp != OKAY) begin
            err <= 1'b1;
            done <= 1'b1;
          end
        end
        default: cnt <= cnt - 1'b1;
      endcase
      if (load) begin
        state <= ISSUE;
        idx <= rd_addr;
        m_awvalid <= 1'b1;
        m_wvalid <= 1'b1;
        m_awaddr <= ent.sel ? AW'(CAPCTL_OENABLE_OFF) : AW'(CAPCTL_ODATA_OFF);
        m_wdata <= 32'(ent.data);
        cur_delay <= ent.delay;
      end
      if (adv && fin) begin
        state <= IDLE;
        done <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_capctl_seq.sv
// tb_capctl_seq: randomized self-checking bench for capctl_seq against a cycle-timed behavioural model
module tb_capctl_seq;
  localparam int DEPTH = 16;
  logic clk = 0, reset_n = 0, start = 0, pat_we = 0, loop = 0;
  logic [4:0] len = 0;
  logic [3:0] pat_waddr = 0;
  logic [14:0] pat_wdata = 0;
  logic busy, done, err, m_awvalid, m_wvalid, m_bready;
  logic m_awready = 0, m_wready = 0, m_bvalid = 0;
  logic [31:0] m_awaddr, m_wdata;
  logic [0:0] m_wstrb;
  logic [1:0] m_bresp = 0;
  capctl_seq dut (
    .clk(clk), .reset_n(reset_n),
`ifdef CAPCTL_SEQ_LOOP_EN
    .loop(loop),
`endif
    .start(start), .len(len), .busy(busy), .done(done), .err(err),
    .pat_we(pat_we), .pat_waddr(pat_waddr), .pat_wdata(pat_wdata),
    .m_awvalid(m_awvalid), .m_awready(m_awready), .m_awaddr(m_awaddr),
    .m_wvalid(m_wvalid), .m_wready(m_wready), .m_wdata(m_wdata), .m_wstrb(m_wstrb),
    .m_bvalid(m_bvalid), .m_bready(m_bready), .m_bresp(m_bresp)
  );
  always #5 clk = ~clk;
  int checks = 0, failures = 0, cyc = 0;
  logic [14:0] tab [DEPTH];
  int rise_cyc = -1, done_cyc = -1, busy_cyc = -1, clr_cyc = -1;
  int ent_i = 0, n_ent = 0, n_aw = 0, n_w = 0, n_b = 0, n_done = 0;
  bit mbusy = 0, merr = 0, abort = 0, p_aw = 0, p_w = 0, p_awhs = 0, p_whs = 0, aw_dn = 0, w_dn = 0;
  bit fast = 1, s_aw = 0, s_w = 0, l_awhs = 0, l_whs = 0, l_bhs = 0, skip = 0;
  int txn = 0, err_at = -1, b_lat = 0;
  logic [1:0] bad_resp = 2'b10;
  task automatic check(string tag, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", tag, act, exp, cyc);
    end
  endtask
  function automatic logic [31:0] e_addr(int i);
    return tab[i][14] ? 32'h4 : 32'h0;
  endfunction
  function automatic logic [31:0] e_data(int i);
    return {26'b0, tab[i][13:8]};
  endfunction
  function automatic int e_dly(int i);
    return int'(tab[i][7:0]);
  endfunction
  task automatic slave_drive();
    if (l_bhs) begin
      m_bvalid = 0; s_aw = 0; s_w = 0; txn++;
      b_lat = fast ? 0 : $urandom_range(0, 3);
    end
    s_aw = s_aw | l_awhs;
    s_w = s_w | l_whs;
    if (s_aw && s_w && !m_bvalid && !l_bhs) begin
      if (b_lat == 0) begin
        m_bvalid = 1;
        m_bresp = (txn == err_at) ? bad_resp : 2'b00;
      end else b_lat--;
    end
    m_awready = fast || $urandom_range(0, 2) == 0;
    m_wready = fast || $urandom_range(0, 2) == 0;
  endtask
  task automatic monitor();
    bit aw_hs, w_hs, b_hs;
    aw_hs = m_awvalid && m_awready;
    w_hs = m_wvalid && m_wready;
    b_hs = m_bvalid && m_bready;
    if (cyc == busy_cyc) mbusy = 1;
    if (cyc == clr_cyc) merr = 0;
    if (cyc == done_cyc) begin
      mbusy = 0;
      if (abort) merr = 1;
    end
    check("busy", busy, mbusy);
    check("done", done, cyc == done_cyc);
    check("err", err, merr);
    check("awvalid", m_awvalid, (p_aw && !p_awhs) || cyc == rise_cyc);
    check("wvalid", m_wvalid, (p_w && !p_whs) || cyc == rise_cyc);
    check("bready", m_bready, aw_dn && w_dn);
    if (m_awvalid) check("awaddr", m_awaddr, e_addr(ent_i));
    if (m_wvalid) check("wdata", m_wdata, e_data(ent_i));
    if (done) n_done++;
    if (aw_hs) begin n_aw++; aw_dn = 1; end
    if (w_hs) begin n_w++; w_dn = 1; end
    if (b_hs) begin
      n_b++; aw_dn = 0; w_dn = 0;
      if (m_bresp != 2'b00) begin
        abort = 1;
        done_cyc = cyc + 1;
      end else if (ent_i == n_ent - 1 && !loop) done_cyc = cyc + e_dly(ent_i) + 1;
      else begin
        rise_cyc = cyc + e_dly(ent_i) + 1;
        ent_i = (ent_i + 1) % n_ent;
      end
    end
    p_aw = m_awvalid; p_w = m_wvalid; p_awhs = aw_hs; p_whs = w_hs;
    l_awhs = aw_hs; l_whs = w_hs; l_bhs = b_hs;
  endtask
  task automatic tick();
    @(negedge clk);
    cyc++;
    slave_drive();
    if (!skip) monitor();
  endtask
  task automatic model_reset();
    rise_cyc = -1; done_cyc = -1; busy_cyc = -1; clr_cyc = -1;
    mbusy = 0; merr = 0; abort = 0; p_aw = 0; p_w = 0; p_awhs = 0; p_whs = 0;
    aw_dn = 0; w_dn = 0; s_aw = 0; s_w = 0; l_awhs = 0; l_whs = 0; l_bhs = 0;
    m_bvalid = 0; m_bresp = 0;
  endtask
  task automatic do_reset();
    reset_n = 0; skip = 1;
    tick();
    check("rst_busy", busy, 0);
    check("rst_awvalid", m_awvalid, 0);
    check("rst_wvalid", m_wvalid, 0);
    check("rst_bready", m_bready, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    reset_n = 1;
    model_reset();
    skip = 0;
  endtask
  task automatic wr_pat(logic [3:0] a, logic [14:0] d);
    pat_we = 1; pat_waddr = a; pat_wdata = d;
    if (!mbusy) tab[a] = d;
    tick();
    pat_we = 0;
  endtask
  task automatic do_start(int l);
    start = 1; len = 5'(l);
    clr_cyc = cyc + 1; txn = 0; abort = 0; done_cyc = -1;
    if (l == 0) done_cyc = cyc + 1;
    else begin
      n_ent = l > DEPTH ? DEPTH : l;
      ent_i = 0; rise_cyc = cyc + 1; busy_cyc = cyc + 1;
    end
    tick();
    start = 0;
  endtask
  task automatic wait_end(int budget, bit noise);
    int k = 0;
    while (!(done_cyc >= 0 && cyc >= done_cyc) && k < budget) begin
      if (noise && mbusy)
        case ($urandom_range(0, 9))
          0: begin start = 1; len = 5'($urandom_range(0, 16)); end
          1: begin pat_we = 1; pat_waddr = 4'($urandom); pat_wdata = 15'($urandom); end
          default: ;
        endcase
      tick();
      start = 0; pat_we = 0; k++;
    end
    check("end_in_time", k < budget, 1);
    repeat (3) tick();
  endtask
  task automatic clear_counts();
    n_aw = 0; n_w = 0; n_b = 0; n_done = 0;
  endtask
  task automatic run_seq(int l, int ea, bit f, bit noise, bit fw, logic [14:0] fwd);
    int ne, nexp;
    fast = f; err_at = ea; bad_resp = 2'($urandom_range(1, 3));
    clear_counts();
    ne = l == 0 ? 0 : (l > DEPTH ? DEPTH : l);
    nexp = (ea >= 0 && ea < ne) ? ea + 1 : ne;
    if (fw) begin
      pat_we = 1; pat_waddr = 0; pat_wdata = fwd; tab[0] = fwd;
    end
    do_start(l);
    pat_we = 0;
    wait_end(4000, noise);
    check("n_aw", n_aw, nexp);
    check("n_w", n_w, nexp);
    check("n_b", n_b, nexp);
    check("n_done", n_done, 1);
  endtask
  initial begin
    int k, l, ea;
    do_reset();
    for (int i = 0; i < DEPTH; i++)
      wr_pat(4'(i), {1'($urandom), 6'($urandom), 8'($urandom_range(0, 3))});
    wr_pat(0, {1'b0, 6'h15, 8'd0});
    wr_pat(1, {1'b1, 6'h3F, 8'd2});
    wr_pat(2, {1'b0, 6'h2A, 8'd0});
    run_seq(3, -1, 1, 0, 0, 0);
    check("wstrb", m_wstrb, 1);
    run_seq(3, -1, 0, 0, 0, 0);
    run_seq(4, 1, 0, 0, 0, 0);
    run_seq(2, -1, 1, 0, 0, 0);
    run_seq(0, -1, 1, 0, 0, 0);
    run_seq(20, -1, 1, 0, 0, 0);
    run_seq(2, -1, 1, 0, 1, {1'b1, 6'h0B, 8'd1});
    run_seq(5, -1, 0, 1, 0, 0);
    clear_counts();
    fast = 0; err_at = -1;
    do_start(3);
    k = 0;
    while (!(m_awvalid && ent_i == 1) && k < 300) begin tick(); k++; end
    check("rst_mid_reached", k < 300, 1);
    do_reset();
    repeat (2) tick();
    run_seq(3, -1, 1, 0, 0, 0);
    repeat (25) begin
      if ($urandom_range(0, 1) == 1)
        wr_pat(4'($urandom), {1'($urandom), 6'($urandom), 8'($urandom_range(0, 4))});
      l = $urandom_range(0, 18);
      ea = $urandom_range(0, 3) == 0 ? $urandom_range(0, 5) : -1;
      run_seq(l, ea, 1'($urandom), 1, 0, 0);
    end
`ifdef CAPCTL_SEQ_LOOP_EN
    loop = 1; fast = 1; err_at = -1;
    clear_counts();
    do_start(2);
    repeat (40) tick();
    k = 0;
    while (!(m_awvalid && ent_i == 0) && k < 100) begin tick(); k++; end
    check("loop_reached", k < 100, 1);
    loop = 0;
    wait_end(500, 0);
    check("loop_done", n_done, 1);
    check("loop_even", n_aw % 2, 0);
    check("loop_many", n_aw > 4, 1);
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
